// File: rtl/regfile_ctx_engine_if.sv
// Command, register-file and stream signals of the context save/restore engine.
//   slave  : engine side. It takes commands, drives the RF ports and the SAVE stream,
//            and sinks the RESTORE stream.
//   master : environment side. It issues commands, provides the register file and
//            the stream partners.
interface regfile_ctx_engine_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 16
);
    logic                  cmd_valid;
    logic                  cmd_op;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] rf_r_addr;
    logic [DATA_WIDTH-1:0] rf_r_data;
    logic [ADDR_WIDTH-1:0] rf_w_addr;
    logic [DATA_WIDTH-1:0] rf_w_data;
    logic                  rf_w_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_idx;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  busy;
    logic                  done;

    modport slave (
        input  cmd_valid, cmd_op, rf_r_data, out_ready, in_valid, in_data,
        output cmd_ready, rf_r_addr, rf_w_addr, rf_w_data, rf_w_en,
               out_valid, out_data, out_idx, in_ready, busy, done
    );

    modport master (
        output cmd_valid, cmd_op, rf_r_data, out_ready, in_valid, in_data,
        input  cmd_ready, rf_r_addr, rf_w_addr, rf_w_data, rf_w_en,
               out_valid, out_data, out_idx, in_ready, busy, done
    );
endinterface

// File: rtl/regfile_ctx_engine.sv
// Register-file context engine. It moves N_ELEMENTS register-file entries in index order.
//   SAVE    (cmd_op=0): reads the register file and sends each entry on the out_* stream.
//   RESTORE (cmd_op=1): takes entries from the in_* stream and writes them to the register file.
// Ports:
//   clk, rst : clock, synchronous active-high reset.
//   bus      : slave modport. It carries the command handshake, the RF read and write
//              ports, the SAVE and RESTORE streams, and the busy/done status.
module regfile_ctx_engine #(
    parameter int N_ELEMENTS = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst,
    regfile_ctx_engine_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N_ELEMENTS - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  xfer;

    assign xfer = ((state == SAVE) && bus.out_ready) || ((state == RESTORE) && bus.in_valid);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state. cnt goes back to 0 on the last transfer, so it never passes LAST
    // even when N_ELEMENTS is not a power of two.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (bus.cmd_valid) begin
                cnt_nxt   = '0;
                state_nxt = bus.cmd_op ? RESTORE : SAVE;
            end
            SAVE, RESTORE: if (xfer) begin
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs. The transfer strobes are masked by rst. A reset edge that lands during a
    // command would otherwise complete one last write or handshake, because the state
    // still reads SAVE/RESTORE until that edge.
    always_comb begin
        bus.cmd_ready = (state == IDLE);
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
        bus.out_valid = (state == SAVE) && !rst;
        bus.rf_r_addr = (state == SAVE) ? cnt : '0;
        bus.out_data  = bus.rf_r_data;
        bus.out_idx   = cnt;
        bus.in_ready  = (state == RESTORE) && !rst;
        bus.rf_w_en   = (state == RESTORE) && bus.in_valid && !rst;
        bus.rf_w_addr = cnt;
        bus.rf_w_data = bus.in_data;
    end
endmodule

// File: tb/tb_regfile_ctx_engine.sv
module tb_regfile_ctx_engine;
    localparam int AW = 3;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_ctx_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus8 ();
    regfile_ctx_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus5 ();

    regfile_ctx_engine #(.N_ELEMENTS(8), .ADDR_WIDTH(AW), .DATA_WIDTH(DW))
        dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    regfile_ctx_engine #(.N_ELEMENTS(5), .ADDR_WIDTH(AW), .DATA_WIDTH(DW))
        dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));

    // Register files with a combinational read port. pre_* preloads both of them.
    logic [DW-1:0] rf8 [8];
    logic [DW-1:0] rf5 [8];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    assign bus8.rf_r_data = rf8[bus8.rf_r_addr];
    assign bus5.rf_r_data = rf5[bus5.rf_r_addr];

    always @(posedge clk) begin
        if (pre_en) begin
            rf8[pre_addr] <= pre_data;
            rf5[pre_addr] <= pre_data;
        end else if (bus8.rf_w_en === 1'b1) begin
            rf8[bus8.rf_w_addr] <= bus8.rf_w_data;
        end
    end

    // Reference model: the contents the register file should hold.
    logic [DW-1:0] exp_rf [8];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input bit rnd);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pre_en   = 1'b1;
            pre_addr = AW'(i);
            pre_data = rnd ? DW'($urandom) : DW'(16'h1000 + i);
            exp_rf[i] = pre_data;
        end
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // mode 0: out_ready always 1, 1: pattern 1,0,0 repeating, 2: random
    task automatic save8(input int mode);
        int nxt = 0;
        int cyc = 0;
        @(negedge clk);
        bus8.cmd_op = 1'b0; bus8.cmd_valid = 1'b1;
        #1 chk("save_cmd_ready", bus8.cmd_ready, 1);
        @(negedge clk);
        bus8.cmd_valid = 1'b0;
        while (nxt < 8 && cyc < 100) begin
            case (mode)
                0:       bus8.out_ready = 1'b1;
                1:       bus8.out_ready = (cyc % 3 == 0);
                default: bus8.out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            chk("save_valid", bus8.out_valid, 1);
            chk("save_busy", bus8.busy, 1);
            chk("save_cmd_ready_low", bus8.cmd_ready, 0);
            chk("save_no_write", bus8.rf_w_en, 0);
            chk("save_idx", bus8.out_idx, nxt);
            chk("save_data", bus8.out_data, exp_rf[nxt]);
            if (bus8.out_ready) nxt++;
            cyc++;
            @(negedge clk);
        end
        chk("save_count", nxt, 8);
        if (mode == 0) chk("save_latency", cyc, 8);
        bus8.out_ready = 1'b0;
        #1;
        chk("save_done", bus8.done, 1);
        chk("save_done_no_valid", bus8.out_valid, 0);
        chk("save_done_busy", bus8.busy, 1);
        @(negedge clk);
        #1;
        chk("save_done_pulse", bus8.done, 0);
        chk("save_back_idle", bus8.cmd_ready, 1);
    endtask

    task automatic save5();
        int nxt = 0;
        int cyc = 0;
        @(negedge clk);
        bus5.cmd_op = 1'b0; bus5.cmd_valid = 1'b1;
        @(negedge clk);
        bus5.cmd_valid = 1'b0;
        bus5.out_ready = 1'b1;
        while (nxt < 5 && cyc < 50) begin
            #1;
            chk("n5_valid", bus5.out_valid, 1);
            chk("n5_idx", bus5.out_idx, nxt);
            chk("n5_data", bus5.out_data, exp_rf[nxt]);
            nxt++;
            cyc++;
            @(negedge clk);
        end
        #1;
        chk("n5_done", bus5.done, 1);
        chk("n5_no_extra", bus5.out_valid, 0);
        @(negedge clk);
        bus5.out_ready = 1'b0;
        #1;
        chk("n5_idle", bus5.cmd_ready, 1);
    endtask

    // gap: random in_valid gaps; abort_at >= 0: rst once abort_at writes are done;
    // hold: cmd_valid stays high for the whole command
    task automatic restore8(input bit gap, input int abort_at, input bit hold);
        logic [DW-1:0] d [8];
        int nxt = 0;
        int cyc = 0;
        bit aborted = 0;
        for (int i = 0; i < 8; i++) d[i] = gap ? DW'($urandom) : DW'(16'hA000 + i);
        @(negedge clk);
        bus8.cmd_op = 1'b1; bus8.cmd_valid = 1'b1;
        #1 chk("rst_cmd_ready", bus8.cmd_ready, 1);
        @(negedge clk);
        if (!hold) bus8.cmd_valid = 1'b0;
        while (nxt < 8 && cyc < 100) begin
            if (abort_at >= 0 && nxt == abort_at) begin
                rst = 1'b1; bus8.in_valid = 1'b1; bus8.in_data = 16'hDEAD;
                #1 chk("abort_no_write", bus8.rf_w_en, 0);
                @(negedge clk);
                rst = 1'b0; bus8.in_valid = 1'b0;
                #1;
                chk("abort_cmd_ready", bus8.cmd_ready, 1);
                chk("abort_busy", bus8.busy, 0);
                chk("abort_no_done", bus8.done, 0);
                chk("abort_in_ready", bus8.in_ready, 0);
                aborted = 1;
                break;
            end
            bus8.in_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            bus8.in_data  = bus8.in_valid ? d[nxt] : DW'($urandom);
            #1;
            chk("res_in_ready", bus8.in_ready, 1);
            chk("res_wen", bus8.rf_w_en, bus8.in_valid);
            chk("res_waddr", bus8.rf_w_addr, nxt);
            chk("res_wdata", bus8.rf_w_data, bus8.in_data);
            chk("res_cmd_ready_low", bus8.cmd_ready, 0);
            chk("res_no_out", bus8.out_valid, 0);
            if (bus8.in_valid) begin
                exp_rf[nxt] = d[nxt];
                nxt++;
            end
            cyc++;
            @(negedge clk);
        end
        if (!aborted) begin
            chk("res_count", nxt, 8);
            if (!gap) chk("res_latency", cyc, 8);
            bus8.in_valid = 1'b0;
            #1;
            chk("res_done", bus8.done, 1);
            chk("res_done_no_wen", bus8.rf_w_en, 0);
            chk("res_done_cmd_ready", bus8.cmd_ready, 0);
            @(negedge clk);
            #1;
            chk("res_done_pulse", bus8.done, 0);
            chk("res_back_idle", bus8.cmd_ready, 1);
            if (hold) begin
                // cmd_valid still high: the command is accepted only now
                @(negedge clk);
                bus8.cmd_valid = 1'b0;
                #1;
                chk("hold_second_accept", bus8.busy, 1);
                chk("hold_second_in_ready", bus8.in_ready, 1);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                #1 chk("hold_cleared", bus8.busy, 0);
            end
        end else begin
            @(negedge clk);
            #1 chk("abort_still_no_done", bus8.done, 0);
        end
        for (int i = 0; i < 8; i++) chk("rf_contents", rf8[i], exp_rf[i]);
    endtask

    initial begin
        rst = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        bus8.cmd_valid = 0; bus8.cmd_op = 0; bus8.out_ready = 0; bus8.in_valid = 0; bus8.in_data = '0;
        bus5.cmd_valid = 0; bus5.cmd_op = 0; bus5.out_ready = 0; bus5.in_valid = 0; bus5.in_data = '0;
        repeat (2) @(negedge clk);
        bus8.cmd_valid = 1'b1;          // must be ignored on the reset edge
        @(negedge clk);
        #1;
        chk("reset_cmd_ready", bus8.cmd_ready, 1);
        chk("reset_busy", bus8.busy, 0);
        chk("reset_done", bus8.done, 0);
        chk("reset_out_valid", bus8.out_valid, 0);
        chk("reset_in_ready", bus8.in_ready, 0);
        chk("reset_wen", bus8.rf_w_en, 0);
        chk("reset_raddr", bus8.rf_r_addr, 0);
        rst = 1'b0; bus8.cmd_valid = 1'b0;
        @(negedge clk);
        #1 chk("reset_cmd_not_taken", bus8.busy, 0);

        preload(0);
        save8(0);
        save5();
        restore8(0, -1, 0);
        preload(1);
        save8(1);
        save8(2);
        restore8(1, -1, 1);
        preload(1);
        restore8(0, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_ctx_engine.md
REGFILE_CTX_ENGINE -- requirements
Module: regfile_ctx_engine

Interface
REQ-001 SHALL have parameter N_ELEMENTS, default 8, number of register-file entries transferred per command (2..2^ADDR_WIDTH).
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, register-file address width in bits.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, register data width in bits.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_op  in  1  0 = SAVE (register file to stream), 1 = RESTORE (stream to register file).
REQ-008 cmd_ready  out  1  engine idle and accepting a command.
REQ-009 rf_r_addr  out  ADDR_WIDTH  register-file read address (combinational-read port).
REQ-010 rf_r_data  in  DATA_WIDTH  register-file read data for rf_r_addr, same cycle.
REQ-011 rf_w_addr  out  ADDR_WIDTH  register-file write address.
REQ-012 rf_w_data  out  DATA_WIDTH  register-file write data.
REQ-013 rf_w_en  out  1  register-file write enable.
REQ-014 out_valid / out_ready / out_data[DATA_WIDTH] / out_idx[ADDR_WIDTH]  out/in/out/out  SAVE stream; out_idx is the source register index.
REQ-015 in_valid / in_ready / in_data[DATA_WIDTH]  in/out/in  RESTORE stream.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse on command completion.

Function
REQ-018 SHALL implement FSM states IDLE, SAVE, RESTORE, DONE and an index counter cnt of ADDR_WIDTH bits.
REQ-019 IDLE: cmd_ready=1; on cmd_valid, accept the command, set cnt=0, go to SAVE (cmd_op=0) or RESTORE (cmd_op=1) next cycle.
REQ-020 cmd_ready SHALL be 0 outside IDLE; cmd_valid outside IDLE SHALL be ignored, with no queuing.
REQ-021 SAVE: rf_r_addr=cnt, out_valid=1, out_data=rf_r_data, out_idx=cnt; all held stable while out_ready=0.
REQ-022 SAVE transfer occurs on out_valid && out_ready; cnt increments; transfer with cnt==N_ELEMENTS-1 goes to DONE.
REQ-023 RESTORE: in_ready=1, rf_w_addr=cnt, rf_w_data=in_data, rf_w_en = in_valid (same cycle, combinational).
REQ-024 RESTORE transfer occurs on in_valid && in_ready; cnt increments; transfer with cnt==N_ELEMENTS-1 goes to DONE.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE (cmd_ready=1 the following cycle).
REQ-026 Outside SAVE: out_valid=0, rf_r_addr=0. Outside RESTORE: in_ready=0, rf_w_en=0. rf_w_addr=cnt and rf_w_data=in_data at all times.
REQ-027 Exactly N_ELEMENTS stream transfers and, for RESTORE, exactly N_ELEMENTS writes SHALL occur per command, in index order 0..N_ELEMENTS-1.
REQ-028 cnt SHALL never exceed N_ELEMENTS-1, including when N_ELEMENTS is not a power of two.
REQ-029 Latency with no back-pressure: accept cycle, then N_ELEMENTS transfer cycles, then one DONE cycle; next command accepted N_ELEMENTS+2 cycles after the previous accept.
REQ-030 The engine SHALL NOT write the register file during SAVE; out_data reflects live rf_r_data, so external writes during SAVE are visible.

Reset
REQ-031 On a clock edge with rst=1: state=IDLE, cnt=0; after that edge cmd_ready=1, busy=0, done=0, out_valid=0, in_ready=0, rf_w_en=0, rf_r_addr=0.
REQ-032 rst SHALL take priority over every other input; rst mid-command aborts it with no further writes or transfers and no done pulse.
REQ-033 cmd_valid sampled on an edge with rst=1 SHALL NOT be accepted.

Verification
REQ-034 SAVE, regfile preloaded R[i]=0x1000+i, out_ready=1 -> out_data 0x1000..0x1007 with out_idx 0..7 on 8 consecutive cycles, done pulses 1 cycle later.
REQ-035 RESTORE, in_data 0xA000+i, in_valid=1 -> rf_w_en high 8 cycles, rf_w_addr 0..7, regfile R[i]=0xA000+i, done 1 pulse.
REQ-036 SAVE with out_ready toggling 1,0,0,1,... -> each word held stable while stalled; exactly 8 transfers, none duplicated or skipped.
REQ-037 RESTORE with in_valid gaps, plus cmd_valid held high throughout -> writes only on in_valid cycles; second command accepted only after the DONE cycle.
REQ-038 rst asserted after 3 RESTORE writes -> R[0..2] updated, R[3..7] unchanged, no done, cmd_ready=1 after the reset edge.
REQ-039 N_ELEMENTS=5, ADDR_WIDTH=3 -> SAVE emits indices 0..4 only, then done.
